// File: rtl/pwm_peripheral_if.sv
// -----------------------------------------------------------------------------
// pwm_peripheral_if
//
// Purpose: bundles the register-block side of the PWM peripheral, which are
// the enable, mode and duty-cycle registers, together with the pin-side
// results.
//
// Signals:
//   en_reg_out_7_0   [7:0]  output enable for out[7:0]    (1 = enabled)
//   en_reg_out_15_8  [7:0]  output enable for out[15:8]
//   en_reg_pwm_7_0   [7:0]  mode for out[7:0]             (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  [7:0]  mode for out[15:8]
//   pwm_duty_cycle   [7:0]  duty code; high time = code/256 of a period, 0xFF = 100 %
//   out              [15:0] driven output pins
//   period_start            one-clk pulse on the first clk of each PWM period
//
// Modports:
//   master  register block / host side (drives the control registers)
//   slave   the PWM peripheral
// -----------------------------------------------------------------------------
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//
// Purpose: a 16-channel PWM output block. A single prescaler and an 8-bit
// period counter produce one shared PWM waveform. Each pin is either off,
// static high, or driven by that waveform, so every PWM pin stays
// phase-aligned.
//
// Parameters:
//   PRESCALE  clk cycles per PWM counter step (1..65535). The PWM period is
//             256*PRESCALE clks.
//
// Ports:
//   clk    single clock for all logic
//   rst_n  asynchronous active-low reset
//   bus    pwm_peripheral_if.slave. It carries the enable, mode and duty
//          registers (all synchronous to clk) and returns out and
//          period_start.
//
// Optional feature (macro PWM_SHADOW_EN):
//   When this macro is defined, the duty code is captured into duty_shadow_reg
//   when the counter wraps. A duty change therefore takes effect only at the
//   start of the next period. When it is undefined, the live duty code is
//   compared every clk.
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_peripheral_if.slave bus
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [15:0] prescale_cnt_reg;
    logic [7:0]  pwm_cnt_reg;
    logic        pwm_sig_reg;
    logic        period_start_reg;

    logic        step_tick;
    logic        wrap;
    logic [7:0]  duty_eff;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] out_vec;

    assign step_tick = (prescale_cnt_reg == PRESCALE_LAST);
    // The last step of the period: pwm_cnt goes 255 -> 0 on this edge.
    assign wrap      = step_tick && (pwm_cnt_reg == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_cnt_reg <= '0;
            pwm_cnt_reg      <= '0;
            period_start_reg <= 1'b0;
        end else begin
            if (step_tick) begin
                prescale_cnt_reg <= '0;
                pwm_cnt_reg      <= pwm_cnt_reg + 8'd1;
            end else begin
                prescale_cnt_reg <= prescale_cnt_reg + 16'd1;
            end
            // period_start is registered together with the wrapped counter, so
            // it goes high in the same clk that pwm_cnt reads 0. The count that
            // starts after reset does not wrap, so it produces no pulse.
            period_start_reg <= wrap;
        end
    end

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_shadow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow_reg <= 8'h00;
        end else if (wrap) begin
            duty_shadow_reg <= bus.pwm_duty_cycle;
        end
    end

    assign duty_eff = duty_shadow_reg;
`else
    assign duty_eff = bus.pwm_duty_cycle;
`endif

    // 0xFF is a special code for 100 % duty. A plain compare would leave one
    // step low in every period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_sig_reg <= 1'b0;
        end else if (duty_eff == 8'hFF) begin
            pwm_sig_reg <= 1'b1;
        end else begin
            pwm_sig_reg <= (pwm_cnt_reg < duty_eff);
        end
    end

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // The enables and modes are applied combinationally, so a register write
    // shows up on the pins in the same clk. Pins do not wait for a period
    // boundary.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_out
            assign out_vec[gi] = en_out[gi] & (~en_pwm[gi] | pwm_sig_reg);
        end
    endgenerate

    assign bus.out          = out_vec;
    assign bus.period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//
// Purpose: self-checking bench for pwm_peripheral. The stimulus process drives
// the control registers once per clk. It keeps a reference model of the
// peripheral, based on the elapsed clk count since reset, and pushes the
// expected pin state into a queue. A separate monitor pops one entry on every
// falling edge and compares it with the DUT. The monitor also checks the
// spacing between period_start pulses on its own.
// Define PWM_SHADOW_EN for both the DUT and the bench to check the shadowed
// duty build.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int P      = 13;
    localparam int PERIOD = 256 * P;

    logic clk = 1'b0;
    logic rst_n;

    pwm_peripheral_if bus();

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] out;
        logic        ps;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Next values that the stimulus wants on the inputs.
    logic        nx_rst;
    logic [15:0] nx_en_out;
    logic [15:0] nx_en_pwm;
    logic [7:0]  nx_duty;

    // Reference model. m_k counts the rising edges since reset was released,
    // so the counter value during the current clk is (m_k / P) % 256.
    int          m_k    = 0;
    logic        m_sig  = 1'b0;
    logic        m_ps   = 1'b0;
`ifdef PWM_SHADOW_EN
    logic [7:0]  m_shadow = 8'h00;
`endif

    function automatic int model_cnt();
        return (m_k / P) % 256;
    endfunction

    // Advance the model across one rising edge, using the inputs held before
    // that edge.
    task automatic model_edge();
        logic [7:0] d;
        if (rst_n) begin
`ifdef PWM_SHADOW_EN
            d = m_shadow;
`else
            d = bus.pwm_duty_cycle;
`endif
            m_sig = (d == 8'hFF) || (model_cnt() < int'(d));
            m_k++;
            m_ps = ((m_k % PERIOD) == 0);
`ifdef PWM_SHADOW_EN
            if (m_ps) m_shadow = bus.pwm_duty_cycle;
`endif
        end
    endtask

    task automatic apply_inputs();
        bus.en_reg_out_7_0  = nx_en_out[7:0];
        bus.en_reg_out_15_8 = nx_en_out[15:8];
        bus.en_reg_pwm_7_0  = nx_en_pwm[7:0];
        bus.en_reg_pwm_15_8 = nx_en_pwm[15:8];
        bus.pwm_duty_cycle  = nx_duty;
        rst_n               = nx_rst;
    endtask

    // One clk: the edge, the model update, the new inputs, then push the
    // expected pin state.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        apply_inputs();
        if (!rst_n) begin
            m_k   = 0;
            m_sig = 1'b0;
            m_ps  = 1'b0;
`ifdef PWM_SHADOW_EN
            m_shadow = 8'h00;
`endif
        end
        for (int i = 0; i < 16; i++) begin
            if (!nx_en_out[i])      e.out[i] = 1'b0;
            else if (!nx_en_pwm[i]) e.out[i] = 1'b1;
            else                    e.out[i] = m_sig;
        end
        e.ps = m_ps;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_cnt(input int target, input string tag);
        int budget;
        budget = PERIOD + 2 * P;
        while (model_cnt() != target && budget > 0) begin
            cycle();
            budget--;
        end
        total++;
        if (model_cnt() != target) begin
            bad++;
            $display("FAIL wait_%s: counter=%0d required=%0d (cycle budget expired)",
                     tag, model_cnt(), target);
        end
    endtask

    // Monitor: the scoreboard compare, plus an independent check of the
    // period_start spacing.
    int idx     = 0;
    int last_ps = 0;

    always @(negedge clk) begin
        exp_t e;
        idx++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.out !== e.out) begin
                bad++;
                $display("FAIL out @%0t: got=%h required=%h", $time, bus.out, e.out);
            end
            total++;
            if (bus.period_start !== e.ps) begin
                bad++;
                $display("FAIL period_start @%0t: got=%b required=%b",
                         $time, bus.period_start, e.ps);
            end
        end
        if (rst_n !== 1'b1) begin
            last_ps = idx + 1;
        end else if (bus.period_start === 1'b1) begin
            total++;
            if (idx - last_ps != PERIOD) begin
                bad++;
                $display("FAIL ps_interval @%0t: got=%0d required=%0d",
                         $time, idx - last_ps, PERIOD);
            end
            last_ps = idx;
        end
    end

    initial begin
        // Reset with the registers already programmed. The static-high pins
        // must follow their enables, and the PWM pins must stay low.
        nx_rst    = 1'b0;
        nx_en_out = 16'hFFFF;
        nx_en_pwm = 16'h00FF;
        nx_duty   = 8'h80;
        apply_inputs();
        run(4);

        // 50 % duty on all pins, with the period starting right after release.
        nx_rst    = 1'b1;
        nx_en_pwm = 16'hFFFF;
        run(2 * PERIOD);

        // The extremes: 0 % for one period, then 100 % for three periods.
        nx_duty = 8'h00;
        run(PERIOD);
        nx_duty = 8'hFF;
        run(3 * PERIOD);

        // A mixed lower byte: 25 % PWM on bits 0 and 2, static high on bits 1
        // and 3, bits 7:4 off. The upper byte is random.
        nx_en_out = {8'($urandom), 8'h0F};
        nx_en_pwm = {8'($urandom), 8'h05};
        nx_duty   = 8'h40;
        run(PERIOD + 10);

        // A duty change in the middle of a period, at counter 0x10.
        nx_en_out = 16'hFFFF;
        nx_en_pwm = 16'hFFFF;
        nx_duty   = 8'h20;
        wait_cnt(8'h80, "mid");
        wait_cnt(0, "wrap");
        wait_cnt(8'h10, "x10");
        nx_duty = 8'hC0;
        run(2 * PERIOD);

        // Random register writes at random times.
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if ($urandom_range(199) == 0) begin
                nx_en_out = 16'($urandom);
                nx_en_pwm = 16'($urandom);
                nx_duty   = 8'($urandom);
            end
            cycle();
        end

        // Reset in the middle of a period, at counter 0x7F, then a full restart.
        nx_en_out = 16'hFFFF;
        nx_en_pwm = 16'hFFFF;
        nx_duty   = 8'h80;
        wait_cnt(8'h7F, "x7f");
        nx_rst = 1'b0;
        run(5);
        nx_rst = 1'b1;
        run(PERIOD + 20);

        // Let the monitor drain the queue.
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL provide parameter PRESCALE, default 13: number of clk cycles per PWM counter step; legal range 1..65535.
REQ-002 SHALL provide port clk  input  1  the single clock for all logic.
REQ-003 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port en_reg_out_7_0  input  8  output enable for out[7:0]; 1 = enabled.
REQ-005 SHALL provide port en_reg_out_15_8  input  8  output enable for out[15:8].
REQ-006 SHALL provide port en_reg_pwm_7_0  input  8  PWM mode select for out[7:0]; 1 = PWM, 0 = static high.
REQ-007 SHALL provide port en_reg_pwm_15_8  input  8  PWM mode select for out[15:8].
REQ-008 SHALL provide port pwm_duty_cycle  input  8  duty cycle code; high time = code/256 of a period, except 0xFF.
REQ-009 SHALL provide port out  output  16  driven output pins.
REQ-010 SHALL provide port period_start  output  1  one-clk pulse at the first clk of each PWM period.
REQ-011 SHALL treat all control inputs as synchronous to clk; they are register outputs of the SPI register block and need no synchroniser.

Function
REQ-012 SHALL run a prescaler counting 0..PRESCALE-1; it wraps to 0 and issues a step tick on the clk where it equals PRESCALE-1.
REQ-013 SHALL run an 8-bit pwm_cnt that increments by 1 on each step tick and wraps 255 -> 0; period = 256*PRESCALE clk cycles.
REQ-014 SHALL assert period_start for exactly one clk, registered, on the clk where pwm_cnt becomes 0 via wrap; no pulse on the first period after reset.
REQ-015 SHALL compute pwm_sig = 1 when pwm_cnt < duty_eff, where duty_eff is the effective duty (REQ-025/026).
REQ-016 SHALL force pwm_sig = 1 constantly when duty_eff = 0xFF (100 % duty); duty_eff = 0x00 SHALL give pwm_sig = 0 constantly.
REQ-017 SHALL register pwm_sig, so out lags the counter compare by exactly 1 clk.
REQ-018 SHALL compute out[i] for i in 0..15, combinationally from registered pwm_sig and the current enable inputs: en_out[i]=0 -> 0; en_out[i]=1, en_pwm[i]=0 -> 1; en_out[i]=1, en_pwm[i]=1 -> pwm_sig.
REQ-019 SHALL apply enable and mode changes to out in the same clk they change, without waiting for a period boundary.
REQ-020 SHALL generate every enabled PWM bit from the single shared pwm_sig, so all PWM outputs are phase-aligned.

Reset
REQ-021 SHALL, while rst_n = 0, hold the prescaler = 0, pwm_cnt = 0, pwm_sig = 0, period_start = 0 and duty_shadow = 0x00.
REQ-022 SHALL, with rst_n = 0, drive out to the value of REQ-018 with pwm_sig = 0; out = 0 when the upstream registers are also reset.
REQ-023 SHALL, on assertion of rst_n mid-period, abandon the period immediately and take no partial-period action.
REQ-024 SHALL, after rst_n deasserts, start counting on the first clk edge; the first step tick occurs PRESCALE clks later.

Configuration
REQ-025 SHALL, with macro PWM_SHADOW_EN defined, latch pwm_duty_cycle into duty_shadow on the clk where pwm_cnt wraps to 0, and use duty_shadow as duty_eff, so a duty change never truncates or extends the current period.
REQ-026 SHALL, without PWM_SHADOW_EN, use pwm_duty_cycle directly as duty_eff; a mid-period change takes effect at the next compare, and duty_shadow SHALL not exist.

Verification
REQ-027 SHALL cover: PRESCALE=13, duty=0x80, both en regs 0xFF -> every out bit high for 128*13 clks and low for 128*13 clks per period; period 3328 clks.
REQ-028 SHALL cover: duty=0x00 -> PWM outs constant 0; duty=0xFF -> PWM outs constant 1 across 3 full periods.
REQ-029 SHALL cover: en_reg_out_7_0=0x0F, en_reg_pwm_7_0=0x05, duty=0x40 -> out[0], out[2] pulse at 25 %; out[1], out[3] constant 1; out[7:4] constant 0.
REQ-030 SHALL cover: with PWM_SHADOW_EN, duty changed 0x20 -> 0xC0 at pwm_cnt=0x10 -> current period high time 32 steps, next period 192 steps; without the macro, the current period's high time changes at the next compare.
REQ-031 SHALL cover: rst_n pulsed low at pwm_cnt=0x7F -> out=0, period_start=0 during reset; after release, pwm_cnt restarts at 0 and the first period_start occurs 256*13 clks later.
REQ-032 SHALL cover: period_start pulse width = 1 clk and interval = 256*PRESCALE clks, checked over 4 periods.
